// File: rtl/shift_sample_nb.sv
// Per-channel shift sampler with snapshot, serial scan readout and optional edge counters (SHIFT_SAMPLE_EDGE_CNT_EN).
// DATA_VALID rises max(SAMPLE_LEN,1)+1 cycles after START; no backpressure, START ignored while BUSY.
module shift_sample_nb #(
   parameter int DEPTH    = 3,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      START,
   input  logic [7:0]                SAMPLE_LEN,
   input  logic [CHANNELS-1:0]       SHIFT_IN,
   input  logic                      READ_REQ,
   output logic [CHANNELS*DEPTH-1:0] DATA_OUT,
   output logic                      DATA_VALID,
   output logic                      SCAN_OUT,
   output logic                      SCAN_VALID,
   output logic                      BUSY,
   output logic [CHANNELS*CNT_W-1:0] EDGE_CNT
);

   localparam int NB    = CHANNELS * DEPTH;
   localparam int IDX_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, SAMPLE, HOLD, READOUT} state_t;

   state_t           state_q, state_d;
   logic [NB-1:0]    stage_q, stage_shift;
   logic [7:0]       len_q;
   logic [IDX_W-1:0] bit_idx_q;
   logic             accept_start, last_shift, go_read, last_bit;

   always_comb begin
      stage_shift = stage_q;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (s == 0) stage_shift[c*DEPTH] = SHIFT_IN[c];
            else        stage_shift[c*DEPTH+s] = stage_q[c*DEPTH+s-1];
         end
      end
   end

   assign accept_start = START && ((state_q == IDLE) || (state_q == HOLD));
   assign last_shift   = (state_q == SAMPLE) && (len_q == 8'd1);
   assign go_read      = (state_q == HOLD) && READ_REQ && !START;
   assign last_bit     = (state_q == READOUT) && (bit_idx_q == IDX_W'(NB-1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_start) state_d = SAMPLE;
         SAMPLE:  if (last_shift)   state_d = HOLD;
         HOLD: begin
            if (accept_start)       state_d = SAMPLE;
            else if (go_read)       state_d = READOUT;
         end
         READOUT: if (last_bit)     state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stage_q    <= '0;
         len_q      <= '0;
         DATA_OUT   <= '0;
         DATA_VALID <= 1'b0;
         bit_idx_q  <= '0;
      end else begin
         if (accept_start) begin
            stage_q    <= '0;
            len_q      <= (SAMPLE_LEN == 8'd0) ? 8'd1 : SAMPLE_LEN;
            DATA_VALID <= 1'b0;
         end else if (state_q == SAMPLE) begin
            stage_q <= stage_shift;
            len_q   <= len_q - 8'd1;
            if (last_shift) begin
               DATA_OUT   <= stage_shift;
               DATA_VALID <= 1'b1;
            end
         end
         if (go_read)                   bit_idx_q <= '0;
         else if (state_q == READOUT)   bit_idx_q <= bit_idx_q + IDX_W'(1);
      end
   end

   // Scan outputs decode straight from registered state, so they drop the moment reset hits.
   assign BUSY       = (state_q == SAMPLE) || (state_q == READOUT);
   assign SCAN_VALID = (state_q == READOUT);
   assign SCAN_OUT   = SCAN_VALID & DATA_OUT[bit_idx_q];

`ifdef SHIFT_SAMPLE_EDGE_CNT_EN
   logic [CNT_W-1:0] cnt_q [CHANNELS];

   // A rising edge is the new sample being 1 while the previous one (stage0) was 0.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      end else if (accept_start) begin
         for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      end else if (state_q == SAMPLE) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (SHIFT_IN[c] && !stage_q[c*DEPTH] && (cnt_q[c] != {CNT_W{1'b1}}))
               cnt_q[c] <= cnt_q[c] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      EDGE_CNT = '0;
      for (int c = 0; c < CHANNELS; c++) EDGE_CNT[c*CNT_W +: CNT_W] = cnt_q[c];
   end
`else
   assign EDGE_CNT = '0;
`endif

endmodule

// File: tb/tb_shift_sample_nb.sv
// Directed bench for shift_sample_nb: DEPTH=3, CHANNELS=4, CNT_W=2.
module tb_shift_sample_nb;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        START;
   logic [7:0]  SAMPLE_LEN;
   logic [3:0]  SHIFT_IN;
   logic        READ_REQ;
   logic [11:0] DATA_OUT;
   logic        DATA_VALID;
   logic        SCAN_OUT;
   logic        SCAN_VALID;
   logic        BUSY;
   logic [7:0]  EDGE_CNT;

   int checks = 0;
   int errors = 0;

   shift_sample_nb #(.DEPTH(3), .CHANNELS(4), .CNT_W(2)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .START      (START),
      .SAMPLE_LEN (SAMPLE_LEN),
      .SHIFT_IN   (SHIFT_IN),
      .READ_REQ   (READ_REQ),
      .DATA_OUT   (DATA_OUT),
      .DATA_VALID (DATA_VALID),
      .SCAN_OUT   (SCAN_OUT),
      .SCAN_VALID (SCAN_VALID),
      .BUSY       (BUSY),
      .EDGE_CNT   (EDGE_CNT)
   );

   always #5 CLK = ~CLK;

`ifdef SHIFT_SAMPLE_EDGE_CNT_EN
   localparam logic [7:0] CNT_HALF = 8'hAA;
   localparam logic [7:0] CNT_SAT  = 8'hFF;
   localparam logic [7:0] CNT_ONE  = 8'h55;
`else
   localparam logic [7:0] CNT_HALF = 8'h00;
   localparam logic [7:0] CNT_SAT  = 8'h00;
   localparam logic [7:0] CNT_ONE  = 8'h00;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample3(input logic [3:0] x1, input logic [3:0] x2, input logic [3:0] x3);
      START = 1'b1; SAMPLE_LEN = 8'd3;
      tick();
      START = 1'b0; SHIFT_IN = x1;
      tick();
      SHIFT_IN = x2;
      tick();
      SHIFT_IN = x3;
      tick();
      SHIFT_IN = 4'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [11:0] exp_a5c;
      int n;
      exp_a5c    = 12'hA5C;
      RST_N      = 1'b0;
      START      = 1'b0;
      SAMPLE_LEN = 8'd0;
      SHIFT_IN   = 4'h0;
      READ_REQ   = 1'b0;

      #2;
      check("rst_dv",   64'(DATA_VALID), 64'd0);
      check("rst_busy", 64'(BUSY),       64'd0);
      check("rst_sv",   64'(SCAN_VALID), 64'd0);
      check("rst_so",   64'(SCAN_OUT),   64'd0);
      check("rst_data", 64'(DATA_OUT),   64'd0);
      check("rst_cnt",  64'(EDGE_CNT),   64'd0);
      tick(); tick();
      RST_N = 1'b1;
      tick();

      // Channel 0 shifts 1,0,1; snapshot valid 4 cycles after START.
      START = 1'b1; SAMPLE_LEN = 8'd3;
      tick();
      START = 1'b0; SHIFT_IN = 4'h1;
      check("busy_sample", 64'(BUSY),       64'd1);
      check("dv_cleared",  64'(DATA_VALID), 64'd0);
      tick();
      SHIFT_IN = 4'h0;
      tick();
      SHIFT_IN = 4'h1;
      check("dv_early", 64'(DATA_VALID), 64'd0);
      tick();
      SHIFT_IN = 4'h0;
      check("dv_lat4",    64'(DATA_VALID), 64'd1);
      check("data_101",   64'(DATA_OUT),   64'h005);
      check("busy_hold",  64'(BUSY),       64'd0);

      // Snapshot A5C then full serial readout.
      sample3(4'b1001, 4'b0010, 4'b1110);
      check("dv_a5c",   64'(DATA_VALID), 64'd1);
      check("data_a5c", 64'(DATA_OUT),   64'hA5C);
      READ_REQ = 1'b1;
      tick();
      READ_REQ = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("sv_bit%0d", i), 64'(SCAN_VALID), 64'd1);
         check($sformatf("so_bit%0d", i), 64'(SCAN_OUT),   64'(exp_a5c[i]));
         tick();
      end
      check("sv_done",    64'(SCAN_VALID), 64'd0);
      check("so_done",    64'(SCAN_OUT),   64'd0);
      check("busy_done",  64'(BUSY),       64'd0);
      check("dv_kept",    64'(DATA_VALID), 64'd1);
      check("data_kept",  64'(DATA_OUT),   64'hA5C);

      READ_REQ = 1'b1;
      tick();
      READ_REQ = 1'b0;
      check("read_idle_ignored", 64'(SCAN_VALID), 64'd0);

      // START and READ_REQ together in HOLD: START wins; START inside SAMPLE ignored.
      sample3(4'b1001, 4'b0010, 4'b1110);
      START = 1'b1; READ_REQ = 1'b1; SAMPLE_LEN = 8'd3;
      tick();
      START = 1'b0; READ_REQ = 1'b0;
      check("prio_busy", 64'(BUSY),       64'd1);
      check("prio_dv",   64'(DATA_VALID), 64'd0);
      check("prio_sv",   64'(SCAN_VALID), 64'd0);
      SHIFT_IN = 4'b1001;
      tick();
      START = 1'b1; SHIFT_IN = 4'b0010;
      tick();
      START = 1'b0; SHIFT_IN = 4'b1110;
      tick();
      SHIFT_IN = 4'h0;
      check("start_ign_dv",   64'(DATA_VALID), 64'd1);
      check("start_ign_data", 64'(DATA_OUT),   64'hA5C);

      // Reset after 5 scan bits aborts the readout.
      READ_REQ = 1'b1;
      tick();
      READ_REQ = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("pre_rst_sv", 64'(SCAN_VALID), 64'd1);
      RST_N = 1'b0;
      #1;
      check("mid_rst_sv",   64'(SCAN_VALID), 64'd0);
      check("mid_rst_dv",   64'(DATA_VALID), 64'd0);
      check("mid_rst_busy", 64'(BUSY),       64'd0);
      check("mid_rst_data", 64'(DATA_OUT),   64'd0);
      tick();
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post_rst_sv%0d", i), 64'(SCAN_VALID), 64'd0);
      end

      // SAMPLE_LEN=0 performs exactly one shift, valid 2 cycles after START.
      START = 1'b1; SAMPLE_LEN = 8'd0; SHIFT_IN = 4'hF;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n++;
         START = 1'b0;
         if (DATA_VALID) break;
      end
      SHIFT_IN = 4'h0;
      check("len0_latency", 64'(n),        64'd2);
      check("len0_data",    64'(DATA_OUT), 64'h249);
      check("len0_cnt",     64'(EDGE_CNT), 64'(CNT_ONE));

      // Toggling input for 12 shifts saturates the 2-bit edge counters.
      START = 1'b1; SAMPLE_LEN = 8'd12;
      tick();
      START = 1'b0;
      check("cnt_cleared", 64'(EDGE_CNT), 64'd0);
      for (int i = 0; i < 12; i++) begin
         SHIFT_IN = (i % 2 == 1) ? 4'hF : 4'h0;
         tick();
         if (i == 3) check("cnt_half", 64'(EDGE_CNT), 64'(CNT_HALF));
      end
      SHIFT_IN = 4'h0;
      check("tog_dv",   64'(DATA_VALID), 64'd1);
      check("tog_data", 64'(DATA_OUT),   64'hB6D);
      check("cnt_sat",  64'(EDGE_CNT),   64'(CNT_SAT));
      tick();
      check("cnt_hold", 64'(EDGE_CNT),   64'(CNT_SAT));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_sample_nb.md
SHIFT_SAMPLE_NB -- requirements
Module: shift_sample_nb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3, meaning the shift stages per channel (legal range 2..32).
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of independent sampled inputs (legal range 1..16).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the edge-counter width per channel.
REQ-004 Port CLK: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port RST_N: input, 1 bit, reset; asynchronous and active-low.
REQ-006 Port START: input, 1 bit, request to open a sampling window.
REQ-007 Port SAMPLE_LEN: input, 8 bits, number of shift cycles in the window; latched on accepted START.
REQ-008 Port SHIFT_IN: input, CHANNELS bits, serial input per channel.
REQ-009 Port READ_REQ: input, 1 bit, request for serial readout of the snapshot.
REQ-010 Port DATA_OUT: output, CHANNELS*DEPTH bits, snapshot; channel c stage s at bit c*DEPTH+s.
REQ-011 Port DATA_VALID: output, 1 bit, snapshot valid.
REQ-012 Port SCAN_OUT: output, 1 bit, serial readout data.
REQ-013 Port SCAN_VALID: output, 1 bit, SCAN_OUT qualifier.
REQ-014 Port BUSY: output, 1 bit, high in SAMPLE or READOUT.
REQ-015 Port EDGE_CNT: output, CHANNELS*CNT_W bits, per-channel rising-edge counts.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SAMPLE, HOLD, READOUT.
REQ-017 Transitions: IDLE or HOLD with START=1 -> SAMPLE; at that edge, clear all shift stages, load the length counter with max(SAMPLE_LEN,1), and clear DATA_VALID.
REQ-018 In SAMPLE, each edge SHALL shift every channel: stage0<=SHIFT_IN[c], stage k<=stage k-1; stages SHALL hold in all other states.
REQ-019 The edge performing the final (SAMPLE_LEN-th) shift SHALL load DATA_OUT with the post-shift stage values, set DATA_VALID=1, and enter HOLD; latency from START to DATA_VALID is max(SAMPLE_LEN,1)+1 cycles.
REQ-020 START SHALL be ignored in SAMPLE and READOUT; READ_REQ SHALL be ignored outside HOLD.
REQ-021 HOLD with READ_REQ=1 and START=0 -> READOUT; START SHALL take priority when both are asserted in HOLD.
REQ-022 In READOUT, SCAN_VALID=1 for exactly CHANNELS*DEPTH consecutive cycles, SCAN_OUT presenting DATA_OUT bit 0 first, ascending; after the last bit -> IDLE.
REQ-023 DATA_OUT and DATA_VALID SHALL be retained through READOUT and IDLE until the next accepted START.
REQ-024 SCAN_OUT SHALL be 0 whenever SCAN_VALID=0; BUSY SHALL be registered-state decoded, with no combinational path from inputs.

Reset
REQ-025 RST_N low SHALL immediately force: state IDLE, all shift stages, DATA_OUT, EDGE_CNT, and counters to 0, and DATA_VALID, SCAN_VALID, SCAN_OUT, BUSY to 0.
REQ-026 Reset asserted mid-SAMPLE or mid-READOUT SHALL abort without producing a snapshot or further scan bits; the first START after release SHALL behave as from power-up.

Configuration
REQ-027 Macro SHIFT_SAMPLE_EDGE_CNT_EN defined: per channel, each SAMPLE-state edge where SHIFT_IN[c]=1 and stage0=0 SHALL increment the channel counter, saturating at 2^CNT_W-1; the counters are cleared on accepted START and held otherwise.
REQ-028 Macro SHIFT_SAMPLE_EDGE_CNT_EN undefined: EDGE_CNT SHALL be constant 0 and no counter flops SHALL be instantiated; all other behaviour SHALL be unchanged.

Verification
REQ-029 DEPTH=3, CHANNELS=1, START with SAMPLE_LEN=3, SHIFT_IN=1,0,1 -> DATA_OUT=3'b101 (stage0=1), DATA_VALID high 4 cycles after START.
REQ-030 CHANNELS=4, DEPTH=3, snapshot 12'hA5C, READ_REQ -> SCAN_VALID 12 cycles, SCAN_OUT sequence 0,0,1,1,1,0,1,0,0,1,0,1, then IDLE with BUSY=0.
REQ-031 SAMPLE_LEN=0 -> exactly one shift, DATA_VALID 2 cycles after START.
REQ-032 RST_N pulsed low mid-READOUT after 5 bits -> SCAN_VALID=0 and DATA_VALID=0 immediately, state IDLE, no further bits.
REQ-033 With the EDGE_CNT macro enabled, CNT_W=2, and SHIFT_IN toggling 0/1 for 12 cycles -> EDGE_CNT channel saturates at 3; with the macro disabled -> EDGE_CNT=0.
REQ-034 START and READ_REQ asserted together in HOLD -> enters SAMPLE, DATA_VALID drops, SCAN_VALID stays 0.
